// File: rtl/ram_pkg.sv
// Shared types and sizing for the 4x4 RAM address path.
package ram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned RAM_WORDS  = 4;
  localparam int unsigned RAM_ADDR_W = 2;

  // Number of request lines a given encoded address width must cover.
  function automatic int unsigned req_lines_for(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: first set request at or above the start index, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ADDR_W-1:0]  ptr_i,
  input  logic               rr_en_i,
  output logic [ADDR_W-1:0]  idx_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic               any_o,
  output logic               multi_o
);

  logic [ADDR_W-1:0] start;
  logic [ADDR_W-1:0] cand;
  logic              found;

  always_comb begin
    start    = rr_en_i ? ptr_i : '0;
    cand     = '0;
    found    = 1'b0;
    idx_o    = '0;
    // Address arithmetic wraps naturally because NUM_REQ == 2**ADDR_W.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = start + ADDR_W'(i);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
    any_o    = |req_i;
    multi_o  = ($countones(req_i) > 1);
    onehot_o = '0;
    onehot_o[idx_o] = any_o;
  end

endmodule

// File: rtl/request_address_encoder.sv
// Encodes one-hot-or-more RAM word requests into a held binary address + grant with valid/ready.
module request_address_encoder
  import ram_pkg::*;
#(
  parameter int unsigned NUM_REQ = RAM_WORDS,
  parameter int unsigned ADDR_W  = RAM_ADDR_W,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               multi_o
);

  localparam bit CFG_OK = (NUM_REQ == req_lines_for(ADDR_W));

  if (!CFG_OK) begin : g_bad_cfg
    $error("request_address_encoder: NUM_REQ must equal 2**ADDR_W");
  end

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               multi_q, multi_d;

  logic               accept;
  logic               load;
  logic [ADDR_W-1:0]  pick_ptr;
  logic [ADDR_W-1:0]  pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_any;
  logic               pick_multi;

  assign accept = (state_q == HOLD) && ready_i;
  // A back-to-back load must search from the pointer updated by this accept.
  assign pick_ptr = accept ? ADDR_W'(addr_q + 1'b1) : ptr_q;
  assign load = en_i && pick_any && ((state_q == IDLE) || accept);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (pick_ptr),
    .rr_en_i  (RR_EN),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot),
    .any_o    (pick_any),
    .multi_o  (pick_multi)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    multi_d = multi_q;
    if (accept && RR_EN) begin
      ptr_d = pick_ptr;
    end
    if (load) begin
      state_d = HOLD;
      valid_d = 1'b1;
      addr_d  = pick_idx;
      grant_d = pick_onehot;
      multi_d = pick_multi;
    end else if (accept) begin
      state_d = IDLE;
      valid_d = 1'b0;
      addr_d  = '0;
      grant_d = '0;
      multi_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      grant_q <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign grant_o = grant_q;
  assign multi_o = multi_q;

endmodule
